// File: rtl/pcm_sample_buffer.sv
// PCM capture/playback buffer sitting between the PDM decimator and the I2S
// transmitter. Samples are recorded into an inferred block RAM on command and
// played back one at a time, advancing on each inc_mem pulse from the I2S stage.
module pcm_sample_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16384,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pcm_valid,
    input  logic [DATA_WIDTH-1:0] pcm_data,
    input  logic                  rec_start,
    input  logic                  play_start,
    input  logic                  stop,
    input  logic                  loop,
    input  logic                  inc_mem,
    output logic [DATA_WIDTH-1:0] sample,
    output logic                  start,
    output logic                  recording,
    output logic                  playing,
    output logic                  full
);

    // Counters one bit wider than the address so a full buffer (DEPTH samples)
    // is representable without wrapping back to zero.
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LAST_WR   = (ADDR_WIDTH + 1)'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECORD,
        S_PRIME_ADDR,   // read address for sample 0 is being issued
        S_PRIME_DATA,   // RAM output for sample 0 is captured into sample_q
        S_PLAY
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH:0]     wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]     length_q, length_d;
    logic                    full_q, full_d;
    logic [DATA_WIDTH-1:0]   sample_q, sample_d;
    logic                    wr_en;
    logic [ADDR_WIDTH:0]     last_idx;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   ram_rd_q;

    assign last_idx  = length_q - 1'b1;

    assign sample    = sample_q;
    assign start     = (state_q == S_PLAY);
    assign recording = (state_q == S_RECORD);
    assign playing   = (state_q == S_PLAY);
    assign full      = full_q;

    // Next-state logic: command decode, record pointer handling, playback stepping.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        length_d = length_q;
        full_d   = full_q;
        sample_d = sample_q;
        wr_en    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // stop masks both commands; rec_start wins over play_start.
                if (!stop) begin
                    if (rec_start) begin
                        state_d  = S_RECORD;
                        wr_ptr_d = '0;
                        full_d   = 1'b0;
                    end else if (play_start && (length_q != '0)) begin
                        state_d  = S_PRIME_ADDR;
                        rd_ptr_d = '0;
                    end
                end
            end

            S_RECORD: begin
                if (pcm_valid) begin
                    wr_en    = rst_n;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                end
                // A sample arriving with stop is written first and counted.
                if (pcm_valid && (wr_ptr_q == LAST_WR)) begin
                    state_d  = S_IDLE;
                    length_d = DEPTH_CNT;
                    full_d   = 1'b1;
                end else if (stop) begin
                    state_d  = S_IDLE;
                    length_d = wr_ptr_d;
                end
            end

            S_PRIME_ADDR: begin
                state_d = stop ? S_IDLE : S_PRIME_DATA;
            end

            S_PRIME_DATA: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else begin
                    state_d  = S_PLAY;
                    sample_d = ram_rd_q;
                end
            end

            S_PLAY: begin
                // The RAM is read from rd_ptr_d every cycle, so a pointer step
                // reaches sample_q two cycles after the inc_mem pulse.
                sample_d = ram_rd_q;
                if (stop) begin
                    state_d = S_IDLE;
                end else if (inc_mem) begin
                    if ({1'b0, rd_ptr_q} == last_idx) begin
                        if (loop) begin
                            rd_ptr_d = '0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            length_q <= '0;
            full_q   <= 1'b0;
            sample_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            length_q <= length_d;
            full_q   <= full_d;
            sample_q <= sample_d;
        end
    end

    // Block RAM: single write port, registered read port addressed by the next read pointer.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= pcm_data;
        end
        ram_rd_q <= mem[rd_ptr_d];
    end

endmodule

// File: tb/tb_pcm_sample_buffer.sv
// Self-checking bench for pcm_sample_buffer (DEPTH=8): directed scenarios plus
// randomized record/playback rounds, with a scoreboard checking every sample
// the I2S side latches against a queue-and-array reference model.
module tb_pcm_sample_buffer;

    localparam int DW    = 16;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pcm_valid;
    logic [DW-1:0] pcm_data;
    logic          rec_start;
    logic          play_start;
    logic          stop;
    logic          loop;
    logic          inc_mem;
    logic [DW-1:0] sample;
    logic          start;
    logic          recording;
    logic          playing;
    logic          full;

    pcm_sample_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pcm_valid  (pcm_valid),
        .pcm_data   (pcm_data),
        .rec_start  (rec_start),
        .play_start (play_start),
        .stop       (stop),
        .loop       (loop),
        .inc_mem    (inc_mem),
        .sample     (sample),
        .start      (start),
        .recording  (recording),
        .playing    (playing),
        .full       (full)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int latches = 0;

    // Reference model: what the buffer should hold and how long the recording is.
    logic [DW-1:0] ref_mem [DEPTH];
    int            ref_len  = 0;
    bit            ref_full = 1'b0;
    logic [DW-1:0] rec_data [DEPTH + 4];
    logic [DW-1:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: the I2S stage latches `sample` whenever it pulses inc_mem while start is high.
    always @(negedge clk) begin
        if (rst_n && inc_mem && start) begin
            latches++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL latch_unexpected: got 0x%0h, expected none", sample);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                $display("[TB] latch %0d sample=0x%04h expected=0x%04h", latches, sample, e);
                check("latch_sample", 32'(sample), 32'(e));
            end
        end
    end

    // Record n samples from rec_data; optionally raise stop together with the last one.
    task automatic do_record(input int n, input bit merge_stop);
        int  cnt;
        bit  mrec;
        rec_start = 1'b1;
        tick();
        rec_start = 1'b0;
        check("rec_enter", 32'(recording), 32'd1);
        check("rec_full_clear", 32'(full), 32'd0);
        cnt      = 0;
        mrec     = 1'b1;
        ref_full = 1'b0;
        for (int i = 0; i < n; i++) begin
            pcm_valid = 1'b1;
            pcm_data  = rec_data[i];
            stop      = merge_stop && (i == n - 1);
            tick();
            if (mrec) begin
                ref_mem[cnt] = rec_data[i];
                cnt++;
                if (cnt == DEPTH) begin
                    mrec     = 1'b0;
                    ref_full = 1'b1;
                    ref_len  = DEPTH;
                end else if (stop) begin
                    mrec    = 1'b0;
                    ref_len = cnt;
                end
            end
            pcm_valid = 1'b0;
            stop      = 1'b0;
            check("rec_state", 32'(recording), 32'(mrec));
            repeat ($urandom_range(0, 2)) tick();
        end
        if (mrec) begin
            stop = 1'b1;
            tick();
            stop    = 1'b0;
            mrec    = 1'b0;
            ref_len = cnt;
        end
        check("rec_exit", 32'(recording), 32'd0);
        check("rec_full", 32'(full), 32'(ref_full));
        $display("[TB] recorded %0d offered, length %0d, full %0d", n, ref_len, ref_full);
    endtask

    // Play back with npulses inc_mem pulses; gap = 0 selects random spacing.
    task automatic do_play(input int npulses, input bit lp, input int gap);
        int cur;
        int nxt;
        bit ended;
        loop = lp;
        if (ref_len == 0) begin
            play_start = 1'b1;
            tick();
            play_start = 1'b0;
            repeat (3) begin
                check("empty_play_start", 32'(start), 32'd0);
                check("empty_play_playing", 32'(playing), 32'd0);
                tick();
            end
            return;
        end
        for (int k = 0; k < npulses; k++) begin
            exp_q.push_back(ref_mem[lp ? (k % ref_len) : k]);
        end
        play_start = 1'b1;
        tick();
        play_start = 1'b0;
        check("prime1_start", 32'(start), 32'd0);
        tick();
        check("prime2_start", 32'(start), 32'd0);
        tick();
        check("start_rise", 32'(start), 32'd1);
        check("first_sample", 32'(sample), 32'(ref_mem[0]));
        ended = 1'b0;
        for (int k = 0; k < npulses; k++) begin
            repeat ((gap == 0) ? $urandom_range(1, 10) : gap) tick();
            cur = lp ? (k % ref_len) : k;
            inc_mem = 1'b1;
            tick();
            inc_mem = 1'b0;
            if (!lp && (k == ref_len - 1)) begin
                check("end_start_drop", 32'(start), 32'd0);
                check("end_playing_drop", 32'(playing), 32'd0);
                check("end_sample_hold", 32'(sample), 32'(ref_mem[ref_len - 1]));
                ended = 1'b1;
                break;
            end
            nxt = lp ? ((k + 1) % ref_len) : (k + 1);
            check("step_hold", 32'(sample), 32'(ref_mem[cur]));
            tick();
            check("step_sample", 32'(sample), 32'(ref_mem[nxt]));
            check("step_start", 32'(start), 32'd1);
        end
        if (!ended) begin
            stop = 1'b1;
            tick();
            stop = 1'b0;
            check("stop_start_drop", 32'(start), 32'd0);
        end
        tick();
    endtask

    initial begin
        rst_n      = 1'b0;
        pcm_valid  = 1'b0;
        pcm_data   = '0;
        rec_start  = 1'b0;
        play_start = 1'b0;
        stop       = 1'b0;
        loop       = 1'b0;
        inc_mem    = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        check("rst_start", 32'(start), 32'd0);
        check("rst_recording", 32'(recording), 32'd0);
        check("rst_playing", 32'(playing), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_sample", 32'(sample), 32'd0);

        // Nothing recorded yet: play_start is ignored.
        do_play(2, 1'b0, 0);

        // Five samples then stop; play once, then loop.
        for (int i = 0; i < 5; i++) rec_data[i] = 16'(16'h0011 * (i + 1));
        do_record(5, 1'b0);
        do_play(5, 1'b0, 37);
        // Stray pcm_valid / inc_mem in IDLE must not disturb the recording.
        pcm_valid = 1'b1;
        pcm_data  = 16'hFFFF;
        inc_mem   = 1'b1;
        tick();
        pcm_valid = 1'b0;
        inc_mem   = 1'b0;
        do_play(7, 1'b1, 37);

        // Overfill: auto-stop after DEPTH samples, extra samples dropped.
        for (int i = 0; i < 10; i++) rec_data[i] = 16'(16'h0100 + i);
        do_record(10, 1'b0);
        do_play(DEPTH, 1'b0, 0);

        // Sample with stop in the same cycle is kept.
        rec_data[0] = 16'($urandom);
        rec_data[1] = 16'($urandom);
        rec_data[2] = 16'h0ABC;
        do_record(3, 1'b1);
        do_play(3, 1'b0, 0);

        // Reset while playing discards the recording.
        loop       = 1'b1;
        play_start = 1'b1;
        tick();
        play_start = 1'b0;
        tick();
        tick();
        check("pre_reset_start", 32'(start), 32'd1);
        rst_n = 1'b0;
        tick();
        check("reset_play_start", 32'(start), 32'd0);
        check("reset_play_playing", 32'(playing), 32'd0);
        check("reset_play_full", 32'(full), 32'd0);
        rst_n    = 1'b1;
        ref_len  = 0;
        ref_full = 1'b0;
        do_play(2, 1'b0, 0);

        // Randomized rounds.
        for (int r = 0; r < 8; r++) begin
            int n;
            bit lp;
            n = $urandom_range(1, DEPTH + 2);
            for (int i = 0; i < n; i++) rec_data[i] = 16'($urandom);
            do_record(n, 1'($urandom_range(0, 1)));
            lp = 1'($urandom_range(0, 1));
            do_play(lp ? $urandom_range(1, 2 * ref_len + 1) : $urandom_range(1, ref_len), lp, 0);
        end

        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
